// File: rtl/prbs_gen_injector_if.sv
// PRBS generator control/data bundle: bit strobe, seed load, injection controls and outputs.
// Master drives the controls and observes the streams; slave is the generator itself.
interface prbs_gen_injector_if #(
    parameter int N_PRBS     = 9,
    parameter int NB_PERIOD  = 16,
    parameter int NB_INJ_CNT = 32
);
    logic                  i_enable;
    logic                  i_load_seed;
    logic [N_PRBS-1:0]     i_seed;
    logic [1:0]            i_inj_mode;
    logic                  i_inj_trigger;
    logic [NB_PERIOD-1:0]  i_inj_period;
    logic                  o_ref_bit;
    logic                  o_bit;
    logic                  o_inj_pulse;
    logic [NB_INJ_CNT-1:0] o_inj_count;

    modport master (
        output i_enable, i_load_seed, i_seed, i_inj_mode, i_inj_trigger, i_inj_period,
        input  o_ref_bit, o_bit, o_inj_pulse, o_inj_count
    );

    modport slave (
        input  i_enable, i_load_seed, i_seed, i_inj_mode, i_inj_trigger, i_inj_period,
        output o_ref_bit, o_bit, o_inj_pulse, o_inj_count
    );
endinterface

// File: rtl/prbs_gen_injector.sv
// PRBS source: clean reference bit plus a copy with single-shot/periodic error injection.
// Latency: one clock from an enabled edge to o_ref_bit/o_bit/o_inj_pulse.
// No backpressure: one bit per i_enable cycle; outputs hold while i_enable is low.
module prbs_gen_injector #(
    parameter int                N_PRBS     = 9,
    parameter logic [N_PRBS-1:0] SEED       = 9'h1AA,
    parameter int                NB_PERIOD  = 16,
    parameter int                NB_INJ_CNT = 32
) (
    input logic                  i_clock,
    input logic                  i_reset,
    prbs_gen_injector_if.slave   bus
);
    localparam int TAP = (N_PRBS == 7)  ? 6  :
                         (N_PRBS == 9)  ? 5  :
                         (N_PRBS == 11) ? 9  :
                         (N_PRBS == 15) ? 14 : 1;

    localparam logic [1:0] MODE_SINGLE   = 2'd1;
    localparam logic [1:0] MODE_PERIODIC = 2'd2;

    generate
        if (!(N_PRBS == 7 || N_PRBS == 9 || N_PRBS == 11 || N_PRBS == 15)) begin : g_bad_len
            $error("prbs_gen_injector: N_PRBS must be 7, 9, 11 or 15");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("prbs_gen_injector: SEED must be nonzero");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PERIODIC
    } inj_state_t;

    inj_state_t            state_q, state_d;
    logic [N_PRBS-1:0]     lfsr_q;
    logic [1:0]            mode_q;
    logic [NB_PERIOD-1:0]  cnt_q, cnt_d;
    logic [NB_PERIOD-1:0]  period_eff, period_m1;
    logic [NB_INJ_CNT-1:0] inj_cnt_q;
    logic                  ref_q, bit_q, pulse_q;
    logic                  lock, adv, inj, mode_chg, prbs_b, fb;

    // An all-zero LFSR is a lock-up state; it is reloaded instead of shifted.
    assign lock       = (lfsr_q == '0);
    assign adv        = bus.i_enable & ~bus.i_load_seed & ~lock;
    assign mode_chg   = (bus.i_inj_mode != mode_q);
    assign prbs_b     = lfsr_q[N_PRBS-1];
    assign fb         = lfsr_q[N_PRBS-1] ^ lfsr_q[TAP-1];
    assign period_eff = (bus.i_inj_period < NB_PERIOD'(2)) ? NB_PERIOD'(2) : bus.i_inj_period;
    assign period_m1  = period_eff - NB_PERIOD'(1);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= bus.i_inj_mode;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inj     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_inj_mode == MODE_PERIODIC) begin
                    state_d = ST_PERIODIC;
                end else if (bus.i_inj_mode == MODE_SINGLE && bus.i_inj_trigger) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.i_inj_mode != MODE_SINGLE) begin
                    state_d = ST_IDLE;
                end else if (adv) begin
                    inj     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PERIODIC: begin
                if (bus.i_inj_mode != MODE_PERIODIC) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (adv) begin
                    // >= so a period shrunk below the running count still fires next bit
                    if (cnt_q >= period_m1) begin
                        inj   = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + NB_PERIOD'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (mode_chg) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            lfsr_q <= SEED;
        end else if (bus.i_load_seed) begin
            lfsr_q <= (bus.i_seed == '0) ? SEED : bus.i_seed;
        end else if (lock) begin
            lfsr_q <= SEED;
        end else if (bus.i_enable) begin
            lfsr_q <= {lfsr_q[N_PRBS-2:0], fb};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ref_q     <= 1'b0;
            bit_q     <= 1'b0;
            pulse_q   <= 1'b0;
            inj_cnt_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (adv) begin
                ref_q   <= prbs_b;
                bit_q   <= prbs_b ^ inj;
                pulse_q <= inj;
                if (inj && inj_cnt_q != '1) begin
                    inj_cnt_q <= inj_cnt_q + NB_INJ_CNT'(1);
                end
            end
        end
    end

    assign bus.o_ref_bit   = ref_q;
    assign bus.o_bit       = bit_q;
    assign bus.o_inj_pulse = pulse_q;
    assign bus.o_inj_count = inj_cnt_q;
endmodule

// File: tb/tb_prbs_gen_injector.sv
// Scoreboard bench for prbs_gen_injector: a reference x^9+x^5+1 model predicts each cycle's outputs,
// with injection positions chosen by each scenario.
module tb_prbs_gen_injector;
    localparam int            N    = 9;
    localparam logic [N-1:0]  SEED = 9'h1FF;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    always #5 i_clock = ~i_clock;

    prbs_gen_injector_if #(.N_PRBS(N), .NB_PERIOD(16), .NB_INJ_CNT(32)) bus ();

    prbs_gen_injector #(
        .N_PRBS    (N),
        .SEED      (SEED),
        .NB_PERIOD (16),
        .NB_INJ_CNT(32)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    typedef struct packed {
        logic        ref_bit;
        logic        bit_o;
        logic        pulse;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [N-1:0] m_lfsr;
    logic        m_ref, m_bit, m_pulse;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = SEED;
        m_ref   = 1'b0;
        m_bit   = 1'b0;
        m_pulse = 1'b0;
        m_cnt   = '0;
        sb.delete();
    endtask

    // One clock: drive inputs, predict, push; then after the edge pop and compare.
    task automatic cyc(input logic en, input logic ld, input logic trig,
                       input logic [N-1:0] sd, input logic inj_exp, input string tag);
        exp_t e;
        logic b;
        bus.i_enable      = en;
        bus.i_load_seed   = ld;
        bus.i_seed        = sd;
        bus.i_inj_trigger = trig;
        m_pulse = 1'b0;
        if (ld) begin
            m_lfsr = (sd == '0) ? SEED : sd;
        end else if (en) begin
            b       = m_lfsr[8];
            m_lfsr  = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
            m_ref   = b;
            m_bit   = b ^ inj_exp;
            m_pulse = inj_exp;
            if (inj_exp) m_cnt = m_cnt + 32'd1;
        end
        e.ref_bit = m_ref;
        e.bit_o   = m_bit;
        e.pulse   = m_pulse;
        e.cnt     = m_cnt;
        sb.push_back(e);
        @(posedge i_clock);
        #1;
        e = sb.pop_front();
        check({tag, "_ref"},   bus.o_ref_bit,   e.ref_bit);
        check({tag, "_bit"},   bus.o_bit,       e.bit_o);
        check({tag, "_pulse"}, bus.o_inj_pulse, e.pulse);
        check({tag, "_count"}, bus.o_inj_count, e.cnt);
    endtask

    initial begin
        int k;
        logic en;
        bus.i_enable      = 1'b0;
        bus.i_load_seed   = 1'b0;
        bus.i_seed        = '0;
        bus.i_inj_mode    = 2'd0;
        bus.i_inj_trigger = 1'b0;
        bus.i_inj_period  = '0;
        model_reset();

        #12;
        check("rst_ref",   bus.o_ref_bit,   0);
        check("rst_bit",   bus.o_bit,       0);
        check("rst_pulse", bus.o_inj_pulse, 0);
        check("rst_count", bus.o_inj_count, 0);
        @(negedge i_clock);
        i_reset = 1'b1;

        // Clean stream, no injection; model covers the 511-bit repetition.
        for (int i = 0; i < 520; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, "t1");
            if (i < 9) check("t1_first9", bus.o_ref_bit, 1);
        end
        check("t1_no_inj", bus.o_inj_count, 0);

        // Single shot with extra triggers while armed.
        bus.i_inj_mode = 2'd1;
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, "t2_pre");
        cyc(1'b1, 1'b0, 1'b1, '0, 1'b0, "t2_trig");
        cyc(1'b0, 1'b0, 1'b1, '0, 1'b0, "t2_armed");
        cyc(1'b0, 1'b0, 1'b1, '0, 1'b0, "t2_armed");
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, "t2_inj");
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, "t2_post");
        check("t2_single", bus.o_inj_count, 1);

        // Periodic, P=100, then P clamped from 0 to 2.
        bus.i_inj_mode   = 2'd2;
        bus.i_inj_period = 16'd100;
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, "t3_entry");
        for (int i = 1; i <= 1000; i++) cyc(1'b1, 1'b0, 1'b0, '0, (i % 100) == 0, "t3_p100");
        check("t3_p100_total", bus.o_inj_count, 11);
        bus.i_inj_mode = 2'd0;
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, "t3_exit");
        bus.i_inj_mode   = 2'd2;
        bus.i_inj_period = 16'd0;
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, "t3_entry0");
        for (int i = 1; i <= 20; i++) cyc(1'b1, 1'b0, 1'b0, '0, (i % 2) == 0, "t3_p0");
        check("t3_p0_total", bus.o_inj_count, 21);

        // Zero seed load with enable: no update, then SEED sequence.
        bus.i_inj_mode = 2'd0;
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, "t4_exit");
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, "t4_load");
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, "t4_seq");
            if (i < 9) check("t4_first9", bus.o_ref_bit, 1);
        end

        // Gapped enable, P=4: errors every 4 enabled bits.
        bus.i_inj_mode   = 2'd2;
        bus.i_inj_period = 16'd4;
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, "t5_entry");
        k = 0;
        for (int i = 0; i < 40; i++) begin
            en = (i % 2) == 0;
            if (en) k++;
            cyc(en, 1'b0, 1'b0, '0, en && (k % 4) == 0, "t5_gap");
        end
        check("t5_total", bus.o_inj_count, 26);

        // Async reset mid periodic run at count 7.
        bus.i_inj_mode = 2'd0;
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, "t6_exit");
        @(negedge i_clock);
        i_reset = 1'b0;
        model_reset();
        @(negedge i_clock);
        i_reset = 1'b1;
        bus.i_inj_mode   = 2'd2;
        bus.i_inj_period = 16'd3;
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, "t6_entry");
        for (int i = 1; i <= 21; i++) cyc(1'b1, 1'b0, 1'b0, '0, (i % 3) == 0, "t6_run");
        check("t6_pre_count", bus.o_inj_count, 7);
        #3;
        i_reset = 1'b0;
        #1;
        check("t6_async_ref",   bus.o_ref_bit,   0);
        check("t6_async_bit",   bus.o_bit,       0);
        check("t6_async_pulse", bus.o_inj_pulse, 0);
        check("t6_async_count", bus.o_inj_count, 0);
        model_reset();
        bus.i_inj_mode = 2'd0;
        @(negedge i_clock);
        i_reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, "t6_restart");
            if (i < 9) check("t6_first9", bus.o_ref_bit, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prbs_gen_injector.md
Name: prbs_gen_injector

Overview:
Upstream PRBS source for the BER link. Produces two bit streams per enabled cycle:
- The clean reference bit, consumed by the PRBS checker's reference input.
- A copy of the same bit with controlled error injection, fed into the DSP/channel path.

It provides seed loading, single-shot and periodic error injection, and an injected-error counter, so the checker's BER result can be compared against a known injected count.

Parameters:
- N_PRBS, 9, LFSR length. Legal values: 7 (x^7+x^6+1), 9 (x^9+x^5+1), 11 (x^11+x^9+1), 15 (x^15+x^14+1). Any other value is an elaboration error.
- SEED, 9'h1AA (N_PRBS bits), reset seed. Also the fallback seed. Must be nonzero.
- NB_PERIOD, 16, width of the injection period input.
- NB_INJ_CNT, 32, width of the injected-error counter.

Ports:
- i_clock, in, 1, system clock, rising edge.
- i_reset, in, 1, asynchronous active-low reset.
- i_enable, in, 1, bit strobe; one PRBS bit per cycle where it is high.
- i_load_seed, in, 1, synchronous seed load pulse.
- i_seed, in, N_PRBS, seed value sampled when i_load_seed=1.
- i_inj_mode, in, 2, injection mode: 0 off, 1 single, 2 periodic, 3 reserved (treated as off).
- i_inj_trigger, in, 1, arms one single-shot error (mode 1 only).
- i_inj_period, in, NB_PERIOD, periodic injection interval in enabled bits.
- o_ref_bit, out, 1, clean PRBS bit (to checker i_ref_bit).
- o_bit, out, 1, PRBS bit with injected errors (to DSP/TX path).
- o_inj_pulse, out, 1, high for one cycle when o_bit is updated with an inverted bit.
- o_inj_count, out, NB_INJ_CNT, total injected errors, saturating.

Behaviour:
Reset (async, i_reset=0):
- lfsr=SEED; o_ref_bit=0, o_bit=0, o_inj_pulse=0, o_inj_count=0.
- Period counter=0, FSM=IDLE.

LFSR (enabled cycle, no load):
- Output bit b = lfsr[N_PRBS-1].
- fb = lfsr[N_PRBS-1] ^ lfsr[TAP-1], with TAP per polynomial (5 for N_PRBS=9).
- lfsr <= {lfsr[N_PRBS-2:0], fb}.
- o_ref_bit <= b; o_bit <= b ^ inj; o_inj_pulse <= inj.
- Latency is one clock from the enable edge to the outputs.
- Outputs hold when i_enable=0; o_inj_pulse clears to 0.
- Sequence period is 2^N_PRBS-1 enabled cycles.

Seed load:
- i_load_seed=1 loads lfsr <= i_seed, or SEED if i_seed==0 (lock-up guard).
- Load has priority over i_enable in the same cycle: no shift, no output update, no injection consumed, period counter unchanged.
- Lock-up guard: if lfsr ever reads all-zero, the next edge reloads SEED.

Injection FSM, states IDLE / ARMED / PERIODIC:
- IDLE: inj=0. Go to PERIODIC when i_inj_mode==2. Go to ARMED when i_inj_mode==1 and i_inj_trigger=1.
- ARMED: on the next enabled cycle, inj=1 and return to IDLE. Extra triggers while ARMED are ignored (one error max). If i_inj_mode leaves 1, go to IDLE with no injection.
- PERIODIC: per enabled cycle, if cnt == P-1 then inj=1 and cnt <= 0; else cnt <= cnt+1.
  - P = max(i_inj_period, 2); values 0 and 1 are clamped to 2.
  - If i_inj_mode leaves 2, go to IDLE and clear cnt.
- Any change of i_inj_mode (registered compare against the previous value) clears cnt the same cycle; the first periodic error then lands on the P-th enabled bit after entry.
- i_inj_period changing mid-run takes effect on the next compare. If cnt is already >= P-1, inject on the next enabled bit and wrap to 0.

Counter:
- o_inj_count increments on each inj=1 enabled cycle.
- It saturates at all-ones and never wraps.
- It is cleared only by reset.

Reset mid-operation:
- All state returns to reset values immediately (async).
- The first enabled cycle after release outputs SEED[N_PRBS-1].

Test Plan:
- Reset, SEED=9'h1FF, mode 0, enable high for 520 cycles -> first 9 o_ref_bit=1; stream repeats with period 511; o_bit==o_ref_bit throughout; o_inj_count=0.
- Mode 1, one trigger pulse (then two more while ARMED), enable continuous -> exactly one mismatch o_bit!=o_ref_bit, on the bit after the trigger; o_inj_pulse high one cycle; o_inj_count=1.
- Mode 2, period=100, 1000 enabled bits -> mismatches at enabled bits 100, 200, …, 1000; o_inj_count=10. Repeat with period=0 -> error every 2nd bit.
- Load i_seed=0 with i_enable=1 in the same cycle -> no output update that cycle; the following sequence equals the post-reset SEED sequence.
- Toggle i_enable 1/0 every cycle in mode 2, period=4 -> outputs hold on idle cycles; errors every 4 enabled bits, not every 4 clocks.
- Assert i_reset mid-periodic run (o_inj_count=7) -> outputs and count go to 0 asynchronously; the sequence restarts from SEED.
